// File: rtl/counter_pkg.sv
// counter_pkg
//   Types and helpers shared by the counter front-end controller and the
//   up/down counter bench.
//   CNT_W      : width of the counter's d_in port
//   cnt_t      : counter data word
//   cnt_ctrl_t : the full control bundle driven into the counter
//   ctr_width  : bit width needed for a counter running 0..n-1 (at least 1)
package counter_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic load;
    logic up_down;
    logic enable;
    cnt_t d_in;
  } cnt_ctrl_t;

  // A modulus of 1 still needs a one-bit register so the counter stays legal.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Cleans up one raw push-button: 2-flop synchroniser, hold-time debounce,
//   and a registered one-cycle pulse on every accepted press.
//   Ports:
//     clk   in  system clock, rising-edge
//     rst   in  asynchronous active-high reset
//     raw   in  raw asynchronous button level
//     level out debounced stable level
//     press out one-cycle pulse, one cycle after level rises
module btn_debounce
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = ctr_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] count;

  // Two flops in a row bring the asynchronous button into the clock domain
  // before anything else looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The stable level only moves once the synced input has disagreed with it
  // on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count,
  // so short glitches never reach the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      count <= '0;
    end else if (sync2 != level) begin
      if (count == C_LAST) begin
        level <= ~level;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end else begin
      count <= '0;
    end
  end

  // Rising edges of the stable level become a registered one-cycle press;
  // releases are deliberately ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/counter_cmd_ctrl.sv
// counter_cmd_ctrl
//   Front-end controller sitting directly upstream of the up/down counter.
//   Turns three raw buttons and a switch bank into clean counter controls.
//   Ports:
//     clk      in  system clock, rising-edge
//     rst      in  asynchronous active-high reset
//     btn_load in  raw button: load the switch value into the counter
//     btn_dir  in  raw button: toggle count direction
//     btn_run  in  raw button: toggle run/stop
//     d_sw     in  raw switch bank (synchronised, not debounced)
//     load     out one-cycle load strobe
//     up_down  out 1 = count up, 0 = count down
//     enable   out count-enable pulse, one every TICK_DIV cycles while running
//     d_out    out load value for the counter
//     running  out run/stop status
module counter_cmd_ctrl
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 50_000_000,
  parameter int DATA_W          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_load,
  input  logic              btn_dir,
  input  logic              btn_run,
  input  logic [DATA_W-1:0] d_sw,
  output logic              load,
  output logic              up_down,
  output logic              enable,
  output logic [DATA_W-1:0] d_out,
  output logic              running
);

  localparam int TW = ctr_width(TICK_DIV);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);

  logic              load_ev;
  logic              dir_ev;
  logic              run_ev;
  logic              unused_load_level;
  logic              unused_dir_level;
  logic              unused_run_level;
  logic [DATA_W-1:0] d_sync1;
  logic [DATA_W-1:0] d_sync2;
  logic [TW-1:0]     tick_cnt;
  logic              running_q;
  cnt_ctrl_t         ctrl_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_load),
    .level (unused_load_level),
    .press (load_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_dir),
    .level (unused_dir_level),
    .press (dir_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_run),
    .level (unused_run_level),
    .press (run_ev)
  );

  // Switches only need synchronising; they are sampled solely on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_sync1 <= '0;
      d_sync2 <= '0;
    end else begin
      d_sync1 <= d_sw;
      d_sync2 <= d_sync1;
    end
  end

  // Load strobe, load value, direction and run state. Events arriving on
  // the same edge are all applied together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q.load    <= 1'b0;
      ctrl_q.up_down <= 1'b1;
      ctrl_q.d_in    <= '0;
      running_q      <= 1'b0;
    end else begin
      ctrl_q.load <= load_ev;
      if (load_ev) begin
        ctrl_q.d_in <= cnt_t'(d_sync2);
      end
      if (dir_ev) begin
        ctrl_q.up_down <= ~ctrl_q.up_down;
      end
      if (run_ev) begin
        running_q <= ~running_q;
      end
    end
  end

  // Prescaler: the tick counter restarts on every run toggle, sits at zero
  // while stopped, and restarts on a load so the counter never sees load and
  // enable together. Otherwise each wrap produces one enable cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt      <= '0;
      ctrl_q.enable <= 1'b0;
    end else if (run_ev || !running_q || load_ev) begin
      tick_cnt      <= '0;
      ctrl_q.enable <= 1'b0;
    end else if (tick_cnt == T_LAST) begin
      tick_cnt      <= '0;
      ctrl_q.enable <= 1'b1;
    end else begin
      tick_cnt      <= tick_cnt + TW'(1);
      ctrl_q.enable <= 1'b0;
    end
  end

  assign load    = ctrl_q.load;
  assign up_down = ctrl_q.up_down;
  assign enable  = ctrl_q.enable;
  assign d_out   = DATA_W'(ctrl_q.d_in);
  assign running = running_q;

endmodule
